// File: rtl/dds_output_preprocessor_if.sv
// Bus between the PID-to-DDS preprocessor and its environment: sample input,
// configuration load, DDS completion and the per-field tuning word outputs.
interface dds_output_preprocessor_if #(
    parameter int W_IN   = 18,
    parameter int W_MULT = 16,
    parameter int W_OUT  = 48
);
    logic signed [W_IN-1:0]   data_in;
    logic                     data_dv_in;
    logic [1:0]               chan_sel_in;
    logic signed [W_MULT-1:0] mult_in;
    logic [5:0]               rshift_in;
    logic [W_OUT-1:0]         init_in;
    logic [W_OUT-1:0]         min_in;
    logic [W_OUT-1:0]         max_in;
    logic                     cfg_wr_in;
    logic                     dds_done_in;
    logic [47:0]              freq_out;
    logic                     freq_dv_out;
    logic [13:0]              phase_out;
    logic                     phase_dv_out;
    logic [9:0]               amp_out;
    logic                     amp_dv_out;
    logic                     busy_out;

    modport master (
        output data_in, data_dv_in, chan_sel_in, mult_in, rshift_in,
               init_in, min_in, max_in, cfg_wr_in, dds_done_in,
        input  freq_out, freq_dv_out, phase_out, phase_dv_out,
               amp_out, amp_dv_out, busy_out
    );

    modport slave (
        input  data_in, data_dv_in, chan_sel_in, mult_in, rshift_in,
               init_in, min_in, max_in, cfg_wr_in, dds_done_in,
        output freq_out, freq_dv_out, phase_out, phase_dv_out,
               amp_out, amp_dv_out, busy_out
    );
endinterface

// File: rtl/dds_output_preprocessor.sv
// Scales signed PID samples into clamped DDS tuning words and paces them against dds_done.
// Optional macro OPP_ACCUM_EN: integrate each clamped result into an accumulator used as base.
//
// state        | meaning
// ST_IDLE      | waiting for a new sample or a pending one
// ST_CALC1     | multiply sample by gain
// ST_CALC2     | arithmetic right shift, sign-extend
// ST_CALC3     | add base, clamp to [min,max]
// ST_SEND      | register selected field, pulse its dv
// ST_WAIT_DONE | hold off until dds_done or timeout
module dds_output_preprocessor #(
    parameter int W_IN     = 18,
    parameter int W_MULT   = 16,
    parameter int W_OUT    = 48,
    parameter int DONE_TMO = 255
) (
    input  logic                        clk_in,
    input  logic                        reset_in,
    dds_output_preprocessor_if.slave    bus
);
    localparam int W_PROD = W_IN + W_MULT;
    localparam int W_SUM  = W_OUT + 2;
    localparam int W_TMO  = $clog2(DONE_TMO + 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CALC1,
        ST_CALC2,
        ST_CALC3,
        ST_SEND,
        ST_WAIT_DONE
    } state_t;

    state_t                    r_state;
    state_t                    w_state_nxt;
    logic                      w_start;
    logic                      w_take_pend;
    logic signed [W_IN-1:0]    w_sel_data;

    logic signed [W_MULT-1:0]  r_mult;
    logic [5:0]                r_rshift;
    logic [W_OUT-1:0]          r_init;
    logic [W_OUT-1:0]          r_min;
    logic [W_OUT-1:0]          r_max;

    logic signed [W_IN-1:0]    r_pend_data;
    logic                      r_pend_vld;
    logic signed [W_IN-1:0]    r_data;
    logic [1:0]                r_chan;
    logic signed [W_PROD-1:0]  r_prod;
    logic signed [W_SUM-1:0]   r_sc;
    logic [W_OUT-1:0]          r_result;
    logic [W_TMO-1:0]          r_tmo_cnt;

    logic [W_OUT-1:0]          w_base;
    logic signed [W_SUM-1:0]   w_sum;
    logic [W_OUT-1:0]          w_clamp;

    logic [47:0]               r_freq;
    logic [13:0]               r_phase;
    logic [9:0]                r_amp;
    logic                      r_freq_dv;
    logic                      r_phase_dv;
    logic                      r_amp_dv;

`ifdef OPP_ACCUM_EN
    logic [W_OUT-1:0]          r_acc;

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            r_acc <= '0;
        end else if (bus.cfg_wr_in) begin
            r_acc <= bus.init_in;
        end else if (r_state == ST_CALC3) begin
            r_acc <= w_clamp;
        end
    end

    assign w_base = r_acc;
`else
    assign w_base = r_init;
`endif

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_take_pend = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // Pending sample goes first; a concurrent new sample then refills the slot.
                if (r_pend_vld || bus.data_dv_in) begin
                    w_start     = 1'b1;
                    w_take_pend = r_pend_vld;
                    if (bus.chan_sel_in != 2'd3) begin
                        w_state_nxt = ST_CALC1;
                    end
                end
            end
            ST_CALC1:     w_state_nxt = ST_CALC2;
            ST_CALC2:     w_state_nxt = ST_CALC3;
            ST_CALC3:     w_state_nxt = ST_SEND;
            ST_SEND:      w_state_nxt = ST_WAIT_DONE;
            ST_WAIT_DONE: begin
                if (bus.dds_done_in || (r_tmo_cnt == '0)) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default:      w_state_nxt = ST_IDLE;
        endcase
    end

    assign w_sel_data = w_take_pend ? r_pend_data : bus.data_in;

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            r_mult   <= W_MULT'(1);
            r_rshift <= '0;
            r_init   <= '0;
            r_min    <= '0;
            r_max    <= '1;
        end else if (bus.cfg_wr_in) begin
            r_mult   <= bus.mult_in;
            r_rshift <= bus.rshift_in;
            r_init   <= bus.init_in;
            r_min    <= bus.min_in;
            r_max    <= bus.max_in;
        end
    end

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            r_pend_data <= '0;
            r_pend_vld  <= 1'b0;
        end else if (bus.cfg_wr_in) begin
            r_pend_vld  <= 1'b0;
        end else if (bus.data_dv_in && ((r_state != ST_IDLE) || r_pend_vld)) begin
            r_pend_data <= bus.data_in;
            r_pend_vld  <= 1'b1;
        end else if (w_take_pend) begin
            r_pend_vld  <= 1'b0;
        end
    end

    always_comb begin
        w_sum = $signed({2'b00, w_base}) + r_sc;
        if (r_min > r_max) begin
            w_clamp = r_min;
        end else if (w_sum < $signed({2'b00, r_min})) begin
            w_clamp = r_min;
        end else if (w_sum > $signed({2'b00, r_max})) begin
            w_clamp = r_max;
        end else begin
            w_clamp = w_sum[W_OUT-1:0];
        end
    end

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            r_data     <= '0;
            r_chan     <= '0;
            r_prod     <= '0;
            r_sc       <= '0;
            r_result   <= '0;
            r_tmo_cnt  <= '0;
            r_freq     <= '0;
            r_phase    <= '0;
            r_amp      <= '0;
            r_freq_dv  <= 1'b0;
            r_phase_dv <= 1'b0;
            r_amp_dv   <= 1'b0;
        end else begin
            r_freq_dv  <= 1'b0;
            r_phase_dv <= 1'b0;
            r_amp_dv   <= 1'b0;
            if (w_start) begin
                r_data <= w_sel_data;
                r_chan <= bus.chan_sel_in;
            end
            case (r_state)
                ST_CALC1: r_prod   <= W_PROD'(r_data) * W_PROD'(r_mult);
                ST_CALC2: r_sc     <= W_SUM'(r_prod >>> r_rshift);
                ST_CALC3: r_result <= w_clamp;
                ST_SEND: begin
                    r_tmo_cnt <= W_TMO'(DONE_TMO - 1);
                    case (r_chan)
                        2'd0: begin
                            r_freq    <= r_result[47:0];
                            r_freq_dv <= 1'b1;
                        end
                        2'd1: begin
                            r_phase    <= r_result[13:0];
                            r_phase_dv <= 1'b1;
                        end
                        2'd2: begin
                            r_amp    <= r_result[9:0];
                            r_amp_dv <= 1'b1;
                        end
                        default: ;
                    endcase
                end
                ST_WAIT_DONE: begin
                    if (r_tmo_cnt != '0) begin
                        r_tmo_cnt <= r_tmo_cnt - W_TMO'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.freq_out     = r_freq;
    assign bus.freq_dv_out  = r_freq_dv;
    assign bus.phase_out    = r_phase;
    assign bus.phase_dv_out = r_phase_dv;
    assign bus.amp_out      = r_amp;
    assign bus.amp_dv_out   = r_amp_dv;
    assign bus.busy_out     = (r_state != ST_IDLE);
endmodule

// File: tb/tb_dds_output_preprocessor.sv
// Self-checking bench for dds_output_preprocessor: directed scenarios plus randomized
// samples against an arithmetic reference model (accumulator mode when OPP_ACCUM_EN is set).
module tb_dds_output_preprocessor;
    localparam int W_IN     = 18;
    localparam int W_MULT   = 16;
    localparam int W_OUT    = 48;
    localparam int DONE_TMO = 255;
`ifdef OPP_ACCUM_EN
    localparam bit ACCUM = 1'b1;
`else
    localparam bit ACCUM = 1'b0;
`endif
    localparam longint MAX48 = 64'h0000_FFFF_FFFF_FFFF;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    dds_output_preprocessor_if #(.W_IN(W_IN), .W_MULT(W_MULT), .W_OUT(W_OUT)) dif ();

    dds_output_preprocessor #(
        .W_IN(W_IN), .W_MULT(W_MULT), .W_OUT(W_OUT), .DONE_TMO(DONE_TMO)
    ) dut (
        .clk_in   (clk),
        .reset_in (rst),
        .bus      (dif)
    );

    int n_pass  = 0;
    int n_total = 0;

    longint m_mult, m_rsh, m_init, m_min, m_max, m_acc;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_mult = 1; m_rsh = 0; m_init = 0; m_min = 0; m_max = MAX48; m_acc = 0;
    endtask

    // Expected field value for one sample; updates the model accumulator.
    task automatic model_step(input int data, input int chan, output longint exp_v);
        longint base, prod, sc, sum, r;
        base = ACCUM ? m_acc : m_init;
        prod = longint'(data) * m_mult;
        sc   = prod >>> m_rsh;
        sum  = base + sc;
        if (m_min > m_max)    r = m_min;
        else if (sum < m_min) r = m_min;
        else if (sum > m_max) r = m_max;
        else                  r = sum;
        if (ACCUM) m_acc = r;
        case (chan)
            0:       exp_v = r & MAX48;
            1:       exp_v = r & 64'h3FFF;
            default: exp_v = r & 64'h3FF;
        endcase
    endtask

    task automatic cfg_write(input longint mult, input longint rsh, input longint init,
                             input longint mn, input longint mx);
        dif.mult_in   = mult[W_MULT-1:0];
        dif.rshift_in = rsh[5:0];
        dif.init_in   = init[W_OUT-1:0];
        dif.min_in    = mn[W_OUT-1:0];
        dif.max_in    = mx[W_OUT-1:0];
        dif.cfg_wr_in = 1'b1;
        tick();
        dif.cfg_wr_in = 1'b0;
        m_mult = mult; m_rsh = rsh; m_init = init; m_min = mn; m_max = mx; m_acc = init;
    endtask

    task automatic pulse_sample(input int data, input int chan);
        dif.data_in     = data[W_IN-1:0];
        dif.chan_sel_in = chan[1:0];
        dif.data_dv_in  = 1'b1;
        tick();
        dif.data_dv_in  = 1'b0;
    endtask

    task automatic done_pulse();
        dif.dds_done_in = 1'b1;
        tick();
        dif.dds_done_in = 1'b0;
    endtask

    // Bounded wait for the first dv strobe; lat is 0 when none arrived.
    task automatic wait_dv(input int budget, output int lat, output int which,
                           output longint val, output int n_hi);
        lat = 0; which = -1; val = 0; n_hi = 0;
        for (int k = 1; k <= budget; k++) begin
            tick();
            n_hi = int'(dif.freq_dv_out) + int'(dif.phase_dv_out) + int'(dif.amp_dv_out);
            if (n_hi != 0) begin
                lat = k;
                if (dif.freq_dv_out) begin
                    which = 0; val = longint'(dif.freq_out);
                end else if (dif.phase_dv_out) begin
                    which = 1; val = longint'(dif.phase_out);
                end else begin
                    which = 2; val = longint'(dif.amp_out);
                end
                break;
            end
        end
    endtask

    task automatic test_reset();
        int lat, which, n_hi;
        longint val, exp_v;
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        model_reset();
        n_total++;
        if ({dif.freq_out, dif.phase_out, dif.amp_out} !== 72'd0) $display("FAIL reset_outs got %h want 0", {dif.freq_out, dif.phase_out, dif.amp_out});
        else n_pass++;
        n_total++;
        if ({dif.freq_dv_out, dif.phase_dv_out, dif.amp_dv_out, dif.busy_out} !== 4'b0) $display("FAIL reset_flags got %b want 0000", {dif.freq_dv_out, dif.phase_dv_out, dif.amp_dv_out, dif.busy_out});
        else n_pass++;
        // Default config is unity gain, no shift, zero offset, full range.
        pulse_sample(123, 0);
        model_step(123, 0, exp_v);
        wait_dv(10, lat, which, val, n_hi);
        n_total++;
        if (lat !== 4 || which !== 0 || val !== exp_v) $display("FAIL reset_default_cfg got lat=%0d ch=%0d val=%0d want lat=4 ch=0 val=%0d", lat, which, val, exp_v);
        else n_pass++;
        done_pulse();
    endtask

    task automatic test_basic();
        int lat, which, n_hi;
        longint val, exp_v;
        cfg_write(1, 0, 1000, 0, MAX48);
        pulse_sample(25, 0);
        model_step(25, 0, exp_v);
        wait_dv(10, lat, which, val, n_hi);
        n_total++;
        if (lat !== 4) $display("FAIL basic_latency got %0d want 4", lat);
        else n_pass++;
        n_total++;
        if (val !== 1025 || which !== 0) $display("FAIL basic_freq got ch=%0d val=%0d want ch=0 val=1025", which, val);
        else n_pass++;
        n_total++;
        if (n_hi !== 1) $display("FAIL basic_one_dv got %0d want 1", n_hi);
        else n_pass++;
        tick();
        n_total++;
        if (dif.freq_dv_out !== 1'b0 || dif.busy_out !== 1'b1) $display("FAIL basic_pulse_width got dv=%b busy=%b want dv=0 busy=1", dif.freq_dv_out, dif.busy_out);
        else n_pass++;
        done_pulse();
        n_total++;
        if (dif.busy_out !== 1'b0) $display("FAIL basic_done_idle got busy=%b want 0", dif.busy_out);
        else n_pass++;
    endtask

    task automatic test_clamp();
        int lat, which, n_hi;
        longint val, exp_v;
        cfg_write(-3, 1, 100, 50, MAX48);
        pulse_sample(40, 1);
        model_step(40, 1, exp_v);
        wait_dv(10, lat, which, val, n_hi);
        n_total++;
        if (lat !== 4 || which !== 1 || val !== 50) $display("FAIL clamp_min_phase got lat=%0d ch=%0d val=%0d want lat=4 ch=1 val=50", lat, which, val);
        else n_pass++;
        n_total++;
        if (dif.freq_out !== 48'd1025) $display("FAIL clamp_freq_hold got %0d want 1025", dif.freq_out);
        else n_pass++;
        done_pulse();
        cfg_write(1, 0, 0, 0, 1023);
        pulse_sample(2000, 2);
        model_step(2000, 2, exp_v);
        wait_dv(10, lat, which, val, n_hi);
        n_total++;
        if (which !== 2 || val !== 1023) $display("FAIL clamp_max_amp got ch=%0d val=%0d want ch=2 val=1023", which, val);
        else n_pass++;
        done_pulse();
        cfg_write(1, 0, 0, 0, 1023);
        pulse_sample(-5, 2);
        model_step(-5, 2, exp_v);
        wait_dv(10, lat, which, val, n_hi);
        n_total++;
        if (which !== 2 || val !== 0) $display("FAIL clamp_neg_amp got ch=%0d val=%0d want ch=2 val=0", which, val);
        else n_pass++;
        done_pulse();
        // Inverted bounds force the lower bound.
        cfg_write(1, 0, 5000, 700, 300);
        pulse_sample(1, 0);
        model_step(1, 0, exp_v);
        wait_dv(10, lat, which, val, n_hi);
        n_total++;
        if (which !== 0 || val !== 700) $display("FAIL clamp_inverted got ch=%0d val=%0d want ch=0 val=700", which, val);
        else n_pass++;
        done_pulse();
    endtask

    task automatic test_random();
        int lat, which, n_hi, d, ch, mode;
        longint val, exp_v, mult, rsh, init, a, b;
        for (int it = 0; it < 40; it++) begin
            mult = longint'($urandom_range(0, 65535)) - 32768;
            rsh  = longint'($urandom_range(0, 24));
            init = longint'({$urandom, $urandom}) & MAX48;
            a    = longint'({$urandom, $urandom}) & MAX48;
            b    = longint'({$urandom, $urandom}) & MAX48;
            mode = int'($urandom_range(0, 3));
            case (mode)
                0: cfg_write(mult, rsh, init, 0, MAX48);
                1: cfg_write(mult, rsh, init, (a < b) ? a : b, (a < b) ? b : a);
                2: cfg_write(mult, rsh, init, (a < b) ? b : a, (a < b) ? a : b);
                default: cfg_write(mult, rsh, init & 64'hFFFF_FFFF, 64'h8000_0000 - 64'd3000000, 64'h8000_0000 + 64'd3000000);
            endcase
            for (int s = 0; s < 2; s++) begin
                d  = int'($urandom_range(0, 262143)) - 131072;
                ch = int'($urandom_range(0, 2));
                pulse_sample(d, ch);
                model_step(d, ch, exp_v);
                wait_dv(10, lat, which, val, n_hi);
                n_total++;
                if (lat !== 4 || which !== ch || val !== exp_v) $display("FAIL random_%0d_%0d got lat=%0d ch=%0d val=%0d want lat=4 ch=%0d val=%0d", it, s, lat, which, val, ch, exp_v);
                else n_pass++;
                done_pulse();
            end
        end
    endtask

    task automatic test_pending();
        int lat, which, n_hi;
        longint val, exp_v;
        cfg_write(1, 0, 0, 0, MAX48);
        pulse_sample(5, 0);
        model_step(5, 0, exp_v);
        wait_dv(10, lat, which, val, n_hi);
        n_total++;
        if (val !== exp_v) $display("FAIL pend_first got %0d want %0d", val, exp_v);
        else n_pass++;
        pulse_sample(10, 0);
        pulse_sample(20, 0);
        pulse_sample(30, 0);
        done_pulse();
        model_step(30, 0, exp_v);
        wait_dv(10, lat, which, val, n_hi);
        n_total++;
        if (lat !== 5 || val !== exp_v) $display("FAIL pend_newest got lat=%0d val=%0d want lat=5 val=%0d", lat, val, exp_v);
        else n_pass++;
        done_pulse();
        wait_dv(10, lat, which, val, n_hi);
        n_total++;
        if (lat !== 0 || dif.busy_out !== 1'b0) $display("FAIL pend_single got lat=%0d busy=%b want lat=0 busy=0", lat, dif.busy_out);
        else n_pass++;
        // New sample arriving together with done is deferred, not dropped.
        pulse_sample(40, 0);
        model_step(40, 0, exp_v);
        wait_dv(10, lat, which, val, n_hi);
        dif.data_in     = 18'd77;
        dif.data_dv_in  = 1'b1;
        dif.dds_done_in = 1'b1;
        tick();
        dif.data_dv_in  = 1'b0;
        dif.dds_done_in = 1'b0;
        model_step(77, 0, exp_v);
        wait_dv(10, lat, which, val, n_hi);
        n_total++;
        if (lat !== 5 || val !== exp_v) $display("FAIL pend_done_same got lat=%0d val=%0d want lat=5 val=%0d", lat, val, exp_v);
        else n_pass++;
        done_pulse();
    endtask

    task automatic test_chan3();
        int lat, which, n_hi;
        longint val, exp_v;
        pulse_sample(99, 3);
        n_total++;
        if (dif.busy_out !== 1'b0) $display("FAIL chan3_busy got %b want 0", dif.busy_out);
        else n_pass++;
        wait_dv(8, lat, which, val, n_hi);
        n_total++;
        if (lat !== 0) $display("FAIL chan3_no_dv got lat=%0d want 0", lat);
        else n_pass++;
        pulse_sample(7, 0);
        model_step(7, 0, exp_v);
        wait_dv(10, lat, which, val, n_hi);
        n_total++;
        if (lat !== 4 || val !== exp_v) $display("FAIL chan3_after got lat=%0d val=%0d want lat=4 val=%0d", lat, val, exp_v);
        else n_pass++;
        done_pulse();
    endtask

    task automatic test_timeout();
        int lat, which, n_hi, extra;
        longint val, exp_v;
        pulse_sample(1, 0);
        model_step(1, 0, exp_v);
        wait_dv(10, lat, which, val, n_hi);
        extra = 0;
        for (int k = 0; k < DONE_TMO - 1; k++) begin
            tick();
            extra += int'(dif.freq_dv_out) + int'(dif.phase_dv_out) + int'(dif.amp_dv_out);
        end
        n_total++;
        if (dif.busy_out !== 1'b1) $display("FAIL tmo_still_busy got %b want 1", dif.busy_out);
        else n_pass++;
        tick();
        n_total++;
        if (dif.busy_out !== 1'b0 || extra !== 0) $display("FAIL tmo_release got busy=%b extra_dv=%0d want busy=0 extra_dv=0", dif.busy_out, extra);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        int lat, which, n_hi;
        longint val, exp_v;
        cfg_write(2, 0, 10, 0, MAX48);
        pulse_sample(50, 0);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        model_reset();
        n_total++;
        if ({dif.freq_out, dif.phase_out, dif.amp_out} !== 72'd0 || dif.busy_out !== 1'b0) $display("FAIL rstmid_outs got %h busy=%b want 0 busy=0", {dif.freq_out, dif.phase_out, dif.amp_out}, dif.busy_out);
        else n_pass++;
        wait_dv(10, lat, which, val, n_hi);
        n_total++;
        if (lat !== 0) $display("FAIL rstmid_no_dv got lat=%0d want 0", lat);
        else n_pass++;
        pulse_sample(9, 1);
        model_step(9, 1, exp_v);
        wait_dv(10, lat, which, val, n_hi);
        n_total++;
        if (lat !== 4 || which !== 1 || val !== exp_v) $display("FAIL rstmid_after got lat=%0d ch=%0d val=%0d want lat=4 ch=1 val=%0d", lat, which, val, exp_v);
        else n_pass++;
        done_pulse();
    endtask

`ifdef OPP_ACCUM_EN
    task automatic test_accum();
        int lat, which, n_hi;
        longint val, exp_v;
        int     data_tab [4] = '{10, 10, -30, 10};
        longint want_tab [4] = '{510, 520, 490, 510};
        cfg_write(1, 0, 500, 0, MAX48);
        for (int i = 0; i < 4; i++) begin
            if (i == 3) cfg_write(1, 0, 500, 0, MAX48);
            pulse_sample(data_tab[i], 0);
            model_step(data_tab[i], 0, exp_v);
            wait_dv(10, lat, which, val, n_hi);
            n_total++;
            if (lat !== 4 || val !== want_tab[i]) $display("FAIL accum_%0d got lat=%0d val=%0d want lat=4 val=%0d", i, lat, val, want_tab[i]);
            else n_pass++;
            done_pulse();
        end
    endtask
`endif

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        rst             = 1'b1;
        dif.data_in     = '0;
        dif.data_dv_in  = 1'b0;
        dif.chan_sel_in = 2'd0;
        dif.mult_in     = '0;
        dif.rshift_in   = '0;
        dif.init_in     = '0;
        dif.min_in      = '0;
        dif.max_in      = '0;
        dif.cfg_wr_in   = 1'b0;
        dif.dds_done_in = 1'b0;
        model_reset();
        test_reset();
        test_basic();
        test_clamp();
        test_random();
        test_pending();
        test_chan3();
        test_timeout();
        test_reset_mid();
`ifdef OPP_ACCUM_EN
        test_accum();
`endif
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
